// File: rtl/bp_burst_to_lite_pkg.sv
// Shared types and helpers for the burst-to-Lite reassembler: FSM states,
// BedRock memory message types and the header field widths.
package bp_burst_to_lite_pkg;

    localparam int msg_type_width_gp = 4;
    localparam int subop_width_gp    = 4;
    localparam int msg_size_width_gp = 3;

    typedef enum logic [1:0] {
        e_ready,
        e_data,
        e_out
    } bp_burst_to_lite_state_e;

    typedef enum logic [msg_type_width_gp-1:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3
    } bp_bedrock_mem_type_e;

    // Header layout, LSB first: msg_type, subop, addr, size, payload.
    function automatic int bedrock_header_width(input int paddr_width, input int payload_width);
        return msg_type_width_gp + subop_width_gp + paddr_width + msg_size_width_gp + payload_width;
    endfunction

    // A size code of s means 2^s bytes; even a sub-beat message occupies one beat.
    function automatic int size_to_beats(input logic [msg_size_width_gp-1:0] size, input int beat_bytes);
        int beats;
        beats = (1 << size) / beat_bytes;
        return (beats < 1) ? 1 : beats;
    endfunction

endpackage

// File: rtl/bp_burst_to_lite_sipo.sv
// Serial-in parallel-out beat collector: a beat counter plus the wide data
// register that each accepted beat is written into at the counter's slot.
module bp_burst_to_lite_sipo #(
    parameter int width_p = 64,
    parameter int els_p   = 8,
    localparam int cnt_width_lp = $clog2(els_p + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        beat_v,
    input  logic [width_p-1:0]          beat,
    input  logic [cnt_width_lp-1:0]     len,
    output logic                        last,
    output logic [width_p*els_p-1:0]    word
);

    logic [cnt_width_lp-1:0]  cnt_r;
    logic [width_p*els_p-1:0] data_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r  <= '0;
            data_r <= '0;
        end else if (clear) begin
            cnt_r  <= '0;
            data_r <= '0;
        end else if (beat_v) begin
            for (int i = 0; i < els_p; i++) begin
                if (cnt_r == cnt_width_lp'(i))
                    data_r[i*width_p +: width_p] <= beat;
            end
            cnt_r <= cnt_r + cnt_width_lp'(1);
        end
    end

    // len is the index of the final beat, so the flag fires on that beat's handshake.
    assign last = beat_v & (cnt_r == len);
    assign word = data_r;

endmodule

// File: rtl/bp_burst_to_lite.sv
// Reassembles a BedRock burst (header + narrow beats) into one wide Lite message.
// Optional BP_BURST_TO_LITE_REPLICATE_EN replicates sub-width payloads across the output.
module bp_burst_to_lite
    import bp_burst_to_lite_pkg::*;
#(
    parameter int paddr_width_p    = 40,
    parameter int in_data_width_p  = 64,
    parameter int out_data_width_p = 512,
    parameter int payload_width_p  = 8,
    parameter logic [(1<<msg_type_width_gp)-1:0] payload_mask_p = '0,
    localparam int in_msg_header_width_lp = bedrock_header_width(paddr_width_p, payload_width_p),
    localparam int out_msg_width_lp       = in_msg_header_width_lp + out_data_width_p
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [in_msg_header_width_lp-1:0] in_msg_header_i,
    input  logic                              in_msg_header_v_i,
    output logic                              in_msg_header_ready_and_o,
    input  logic [in_data_width_p-1:0]        in_msg_data_i,
    input  logic                              in_msg_data_v_i,
    output logic                              in_msg_data_ready_and_o,
    output logic [out_msg_width_lp-1:0]       out_msg_o,
    output logic                              out_msg_v_o,
    input  logic                              out_msg_ready_and_i
);

    localparam int burst_words_lp = out_data_width_p / in_data_width_p;
    localparam int cnt_width_lp   = $clog2(burst_words_lp + 1);
    localparam int beat_bytes_lp  = in_data_width_p / 8;
    localparam int size_lsb_lp    = msg_type_width_gp + subop_width_gp + paddr_width_p;

    bp_burst_to_lite_state_e           state;
    logic [in_msg_header_width_lp-1:0] header_r;
    logic                              header_ready_r, data_ready_r, out_v_r;
    logic                              header_hs, data_hs, last;
    logic [cnt_width_lp-1:0]           len;
    logic [out_data_width_p-1:0]       word, out_data;
    logic [msg_type_width_gp-1:0]      in_type;

    function automatic logic [cnt_width_lp-1:0] last_index(input logic [msg_size_width_gp-1:0] size);
        int beats;
        beats = size_to_beats(size, beat_bytes_lp);
        if (beats > burst_words_lp)
            beats = burst_words_lp;
        return cnt_width_lp'(beats - 1);
    endfunction

    assign header_hs = in_msg_header_v_i & header_ready_r;
    assign data_hs   = in_msg_data_v_i & data_ready_r;
    assign in_type   = in_msg_header_i[msg_type_width_gp-1:0];
    assign len       = last_index(header_r[size_lsb_lp +: msg_size_width_gp]);

    bp_burst_to_lite_sipo #(
        .width_p (in_data_width_p),
        .els_p   (burst_words_lp)
    ) sipo (
        .clk     (clk_i),
        .reset_n (reset_n_i),
        .clear   (header_hs),
        .beat_v  (data_hs),
        .beat    (in_msg_data_i),
        .len     (len),
        .last    (last),
        .word    (word)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state          <= e_ready;
            header_r       <= '0;
            header_ready_r <= 1'b1;
            data_ready_r   <= 1'b0;
            out_v_r        <= 1'b0;
        end else begin
            case (state)
                e_ready: if (in_msg_header_v_i) begin
                    header_r       <= in_msg_header_i;
                    header_ready_r <= 1'b0;
                    if (payload_mask_p[in_type]) begin
                        state        <= e_data;
                        data_ready_r <= 1'b1;
                    end else begin
                        state   <= e_out;
                        out_v_r <= 1'b1;
                    end
                end
                e_data: if (last) begin
                    state        <= e_out;
                    data_ready_r <= 1'b0;
                    out_v_r      <= 1'b1;
                end
                e_out: if (out_msg_ready_and_i) begin
                    state          <= e_ready;
                    out_v_r        <= 1'b0;
                    header_ready_r <= 1'b1;
                end
                default: state <= e_ready;
            endcase
        end
    end

`ifdef BP_BURST_TO_LITE_REPLICATE_EN
    // Beat counts are powers of two, so output word j mirrors received word (j mod beats).
    always_comb begin
        out_data = '0;
        for (int j = 0; j < burst_words_lp; j++) begin
            for (int k = 0; k < burst_words_lp; k++) begin
                if (cnt_width_lp'(k) == (cnt_width_lp'(j) & len))
                    out_data[j*in_data_width_p +: in_data_width_p] = word[k*in_data_width_p +: in_data_width_p];
            end
        end
    end
`else
    assign out_data = word;
`endif

    assign in_msg_header_ready_and_o = header_ready_r;
    assign in_msg_data_ready_and_o   = data_ready_r;
    assign out_msg_v_o               = out_v_r;
    assign out_msg_o                 = {out_data, header_r};

`ifndef SYNTHESIS
    a_width_multiple: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (out_data_width_p % in_data_width_p) == 0);
    a_size_fits: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        header_hs |-> size_to_beats(in_msg_header_i[size_lsb_lp +: msg_size_width_gp], beat_bytes_lp) <= burst_words_lp);
`endif

endmodule

// File: tb/tb_bp_burst_to_lite.sv
// Randomized and directed bench for bp_burst_to_lite (64-bit beats, 512-bit Lite data)
// checked against a message-level reference model.
module tb_bp_burst_to_lite;

    localparam int PADDR = 40;
    localparam int PAYLOAD = 8;
    localparam int IW = 64;
    localparam int OWD = 512;
    localparam int HW = 4 + 4 + PADDR + 3 + PAYLOAD;
    localparam int OW = HW + OWD;
    localparam int SIZE_LSB = 4 + 4 + PADDR;
    localparam logic [15:0] MASK = 16'h000A;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [HW-1:0]  in_msg_header_i;
    logic           in_msg_header_v_i;
    logic           in_msg_header_ready_and_o;
    logic [IW-1:0]  in_msg_data_i;
    logic           in_msg_data_v_i;
    logic           in_msg_data_ready_and_o;
    logic [OW-1:0]  out_msg_o;
    logic           out_msg_v_o;
    logic           out_msg_ready_and_i;

    int             n_vec = 0;
    int             n_err = 0;
    int             cyc = 0;
    logic [IW-1:0]  beat_q [8];
    logic [HW-1:0]  cur_hdr;

    bp_burst_to_lite #(
        .paddr_width_p    (PADDR),
        .in_data_width_p  (IW),
        .out_data_width_p (OWD),
        .payload_width_p  (PAYLOAD),
        .payload_mask_p   (MASK)
    ) dut (
        .clk_i                     (clk),
        .reset_n_i                 (reset_n),
        .in_msg_header_i           (in_msg_header_i),
        .in_msg_header_v_i         (in_msg_header_v_i),
        .in_msg_header_ready_and_o (in_msg_header_ready_and_o),
        .in_msg_data_i             (in_msg_data_i),
        .in_msg_data_v_i           (in_msg_data_v_i),
        .in_msg_data_ready_and_o   (in_msg_data_ready_and_o),
        .out_msg_o                 (out_msg_o),
        .out_msg_v_o               (out_msg_v_o),
        .out_msg_ready_and_i       (out_msg_ready_and_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] sz);
        logic [3:0]       subop;
        logic [PADDR-1:0] addr;
        logic [PAYLOAD-1:0] pl;
        subop = 4'($urandom);
        addr  = {8'($urandom), 32'($urandom)};
        pl    = 8'($urandom);
        return {pl, sz, addr, subop, t};
    endfunction

    function automatic int n_beats(input logic [2:0] sz);
        int bytes;
        bytes = 2 ** sz;
        return (bytes < 8) ? 1 : bytes / 8;
    endfunction

    function automatic logic has_data(input logic [HW-1:0] h);
        logic [15:0] m;
        m = MASK;
        return m[h[3:0]];
    endfunction

    // Expected Lite message: header unchanged, beat i in word i, remainder per build option.
    function automatic logic [OW-1:0] expect_msg(input logic [HW-1:0] h);
        logic [OWD-1:0] d;
        int nb;
        d  = '0;
        nb = n_beats(h[SIZE_LSB +: 3]);
        if (has_data(h)) begin
            for (int w = 0; w < 8; w++) begin
                if (w < nb)
                    d[w*IW +: IW] = beat_q[w];
`ifdef BP_BURST_TO_LITE_REPLICATE_EN
                else
                    d[w*IW +: IW] = beat_q[w % nb];
`endif
            end
        end
        return {d, h};
    endfunction

    task automatic send_hdr(input logic [HW-1:0] h, output int t_hdr);
        int t;
        t = 0;
        in_msg_header_i   = h;
        in_msg_header_v_i = 1'b1;
        while (!in_msg_header_ready_and_o && t < 50) begin
            step();
            t++;
        end
        chk("hdr_ready", in_msg_header_ready_and_o, 1'b1);
        step();
        t_hdr = cyc - 1;
        in_msg_header_v_i = 1'b0;
        cur_hdr = h;
    endtask

    task automatic send_beats(input int nb, input int stall_at, input int stall_len);
        int t;
        for (int i = 0; i < nb; i++) begin
            if (i == stall_at) begin
                in_msg_data_v_i = 1'b0;
                repeat (stall_len) step();
            end
            in_msg_data_i   = beat_q[i];
            in_msg_data_v_i = 1'b1;
            t = 0;
            while (!in_msg_data_ready_and_o && t < 50) begin
                step();
                t++;
            end
            if (t == 50)
                chk("beat_ready_timeout", in_msg_data_ready_and_o, 1'b1);
            step();
        end
        in_msg_data_v_i = 1'b0;
    endtask

    task automatic recv(input string tag, input int t_hdr, input int exp_lat, input int out_stall);
        logic [OW-1:0] exp;
        int t;
        t = 0;
        while (!out_msg_v_o && t < 100) begin
            step();
            t++;
        end
        chk({tag, "_v"}, out_msg_v_o, 1'b1);
        chk({tag, "_lat"}, cyc - t_hdr, exp_lat);
        exp = expect_msg(cur_hdr);
        chk({tag, "_msg"}, out_msg_o, exp);
        repeat (out_stall) begin
            step();
            chk({tag, "_stable"}, {out_msg_v_o, in_msg_header_ready_and_o, out_msg_o}, {2'b10, exp});
        end
        out_msg_ready_and_i = 1'b1;
        step();
        out_msg_ready_and_i = 1'b0;
        chk({tag, "_done"}, {out_msg_v_o, in_msg_header_ready_and_o}, 2'b01);
    endtask

    initial begin
        int th;
        int nb, sa, sl, os, lat;
        logic [3:0] t;
        logic [2:0] sz;

        reset_n             = 1'b0;
        in_msg_header_i     = '0;
        in_msg_header_v_i   = 1'b0;
        in_msg_data_i       = '0;
        in_msg_data_v_i     = 1'b0;
        out_msg_ready_and_i = 1'b0;
        #1;
        chk("rst_outputs", {out_msg_v_o, in_msg_data_ready_and_o, out_msg_o}, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("rst_hdr_ready", {in_msg_header_ready_and_o, in_msg_data_ready_and_o, out_msg_v_o}, 3'b100);

        // Full-width write, back-to-back beats 0..7.
        for (int i = 0; i < 8; i++) beat_q[i] = 64'(i);
        send_hdr(mk_hdr(4'd1, 3'd6), th);
        send_beats(8, 99, 0);
        recv("wr64", th, 9, 0);

        // Read: no data ready, output one cycle after the header.
        in_msg_data_i   = 64'h1234;
        in_msg_data_v_i = 1'b1;
        send_hdr(mk_hdr(4'd0, 3'd6), th);
        chk("rd_no_data_ready", in_msg_data_ready_and_o, 1'b0);
        recv("rd64", th, 1, 0);
        in_msg_data_v_i = 1'b0;

        // Sub-width write of a single 8-byte beat.
        beat_q[0] = 64'hDEADBEEF_CAFEF00D;
        send_hdr(mk_hdr(4'd3, 3'd3), th);
        send_beats(1, 99, 0);
        recv("wr8", th, 2, 0);

        // Mid-burst input stall of 3 and output stall of 5.
        for (int i = 0; i < 8; i++) beat_q[i] = {$urandom, $urandom};
        send_hdr(mk_hdr(4'd1, 3'd6), th);
        send_beats(8, 4, 3);
        recv("stall", th, 12, 5);

        // Data valid ahead of its header is held off.
        for (int i = 0; i < 8; i++) beat_q[i] = {$urandom, $urandom};
        in_msg_data_i   = beat_q[0];
        in_msg_data_v_i = 1'b1;
        repeat (3) begin
            step();
            chk("early_data_held", in_msg_data_ready_and_o, 1'b0);
        end
        send_hdr(mk_hdr(4'd1, 3'd6), th);
        send_beats(8, 99, 0);
        recv("early", th, 9, 0);

        // Reset in the middle of a burst.
        send_hdr(mk_hdr(4'd1, 3'd6), th);
        send_beats(3, 99, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_clear", {out_msg_v_o, in_msg_data_ready_and_o, out_msg_o}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("midrst_after", {out_msg_v_o, in_msg_header_ready_and_o, in_msg_data_ready_and_o}, 3'b010);
        beat_q[0] = {$urandom, $urandom};
        send_hdr(mk_hdr(4'd1, 3'd3), th);
        send_beats(1, 99, 0);
        recv("post_rst", th, 2, 0);

        // Random mix of types, sizes and stalls.
        for (int m = 0; m < 40; m++) begin
            t  = 4'($urandom_range(0, 3));
            sz = 3'($urandom_range(0, 6));
            for (int i = 0; i < 8; i++) beat_q[i] = {$urandom, $urandom};
            send_hdr(mk_hdr(t, sz), th);
            os = $urandom_range(0, 3);
            if (has_data(cur_hdr)) begin
                nb = n_beats(sz);
                sa = $urandom_range(0, nb);
                sl = $urandom_range(0, 3);
                send_beats(nb, sa, sl);
                lat = nb + 1 + ((sa < nb) ? sl : 0);
            end else begin
                lat = 1;
            end
            recv("rand", th, lat, os);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bp_burst_to_lite.md
# bp_burst_to_lite

Reassembles a BedRock burst stream (separate header channel plus narrow data beats) into a single wide BedRock Lite message. It is the inverse of the lite-to-burst stage and sits directly downstream of a burst producer, in front of any Lite-only client such as a config bus or a Lite memory endpoint. One message is in flight at a time, and the full payload is buffered before the Lite output is presented.

## Interface
- bp_params_p, e_bp_default_cfg: processor config; supplies paddr_width_p, lce_id_width_p, lce_assoc_p
- in_data_width_p, none (required): burst data beat width, bits
- out_data_width_p, none (required): Lite message data width, bits; a multiple of in_data_width_p and at least as wide
- payload_width_p, none (required): header payload width
- payload_mask_p, 0: bitmask indexed by msg_type; bit set means the message carries data beats
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- in_msg_header_i  in  in_msg_header_width_lp  burst header
- in_msg_header_v_i  in  1  header valid
- in_msg_header_ready_and_o  out  1  header ready (ready-valid-and)
- in_msg_data_i  in  in_data_width_p  data beat
- in_msg_data_v_i  in  1  beat valid
- in_msg_data_ready_and_o  out  1  beat ready (ready-valid-and)
- out_msg_o  out  out_msg_width_lp  Lite message (header plus data)
- out_msg_v_o  out  1  message valid
- out_msg_ready_and_i  in  1  message ready (ready-valid-and)

## Operation
- Derived values:
  - burst_words_lp = out_data_width_p / in_data_width_p
  - beats = max(1, (1 << header.size) / (in_data_width_p/8))
  - The beat counter width is clog2(burst_words_lp + 1).
- The FSM has three states:
  - e_ready: in_msg_header_ready_and_o = 1.
    - On a header handshake, register the header and clear the beat counter and data register.
    - If payload_mask_p[msg_type] is set, go to e_data. Otherwise go to e_out.
  - e_data: in_msg_data_ready_and_o = 1.
    - Each beat handshake writes beat i into data slice [i*in_data_width_p +: in_data_width_p], then increments the counter.
    - When the handshake is on beat index beats-1, go to e_out.
  - e_out: out_msg_v_o = 1, and out_msg_o holds the registered header plus the assembled data.
    - Header and data are stable until out_msg_ready_and_i.
    - On the handshake, go to e_ready.
- No ready is asserted outside its own state. In particular, data beats arriving before their header are held off and never dropped.
- Beats beyond `beats` belong to the next message and are not consumed.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State goes to e_ready.
  - Counter, header register and data register are cleared.
  - out_msg_v_o = 0, in_msg_data_ready_and_o = 0, in_msg_header_ready_and_o = 1 once reset is released.
  - Reset in the middle of a message discards the partial message, and nothing is emitted.
- Latency, with header handshake at cycle N:
  - No-data message: out_msg_v_o is asserted at N+1.
  - k-beat message, beats back-to-back from N+1: out_msg_v_o is asserted at N+k+1.
- Throughput: at best one message per beats+2 cycles. There is a one-cycle bubble after the output handshake before the next header is accepted.
- Stalled input beats extend e_data by the stall count. A stalled output holds e_out indefinitely.
- Simultaneous header-valid and data-valid in e_ready: only the header is taken.

## Configuration
- BP_BURST_TO_LITE_REPLICATE_EN
  - Defined: when beats*in_data_width_p < out_data_width_p, the assembled low region is replicated across the full out_data_width_p on output. This follows the Lite convention for sub-width messages.
  - Undefined: bits above the received beats read zero.
  - Full-width messages are identical in both builds.

## Structure
- The FSM state enum (e_ready, e_data, e_out) goes in bp_me_pkg as bp_burst_to_lite_state_e. Header structs come from the existing bedrock interface macros.
- One sub-module is natural: bp_burst_to_lite_sipo.
  - Contents: the counter plus the data register, with an asynchronous active-low reset.
  - Inputs: clear, beat valid, beat data, len.
  - Outputs: last-beat flag, assembled word.
- Simulation-only assertions:
  - in_data_width_p divides out_data_width_p.
  - header.size never implies more than burst_words_lp beats.

## Test plan
All scenarios use in_data_width_p=64 and out_data_width_p=512.
- Write, size 64B, mask bit set, beats 0x0..0x7 back-to-back: out_msg_v_o at header+9, data word i = i, header passes through unchanged.
- Read, mask bit clear, size 64B: no data ready ever asserted, out_msg_v_o at header+1, data zero.
- Write, size 8B, beat 0xDEADBEEF_CAFEF00D: with REPLICATE_EN all 8 words equal this beat; without it, word 0 equals the beat and words 1-7 are 0.
- Write, 8 beats with data_v deasserted for 3 cycles mid-burst, then out_msg_ready_and_i held low for 5 cycles: the output appears 3 cycles later than the back-to-back case, stays stable during the stall, and the next header is accepted only after the handshake.
- Data valid driven before header valid: in_msg_data_ready_and_o stays 0 until the header is taken, and the first beat lands in word 0.
- reset_n_i pulsed low after beat 3 of 8: outputs clear immediately, no message is emitted, and a following 1-beat message completes correctly.
